// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if
//   Request/response bundle between the core's data-memory port and a
//   memory-side responder.
//
//   Handshake rule (both channels): a transfer happens at a rising clock
//   edge where valid && ready are both high. The sender holds valid and
//   its payload stable until that edge. The receiver may drive ready
//   regardless of valid.
//
//   Signals:
//     req_valid / req_ready  request channel handshake
//     req_addr   [31:0]      byte address
//     req_wdata  [31:0]      store data, right-aligned
//     req_we                 1 = store, 0 = load
//     req_mode   [2:0]       funct3 size/sign encoding
//     rsp_valid / rsp_ready  response channel handshake
//     rsp_rdata  [31:0]      load result (0 for stores and errors)
//     rsp_err                request rejected
//
//   Modports:
//     master  requester side (core)
//     slave   responder side (memory)
// ---------------------------------------------------------------------------
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [2:0]  req_mode;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder. It accepts one load/store at a time
//   and services it LATENCY cycles after accept. It applies RV32I byte, half
//   and word lane rules with sign or zero extension.
//
//   Parameters:
//     DEPTH    number of 32-bit words (power of two, >= 4)
//     LATENCY  cycles from accept to rsp_valid rising (1..15)
//
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous, active-high reset
//     bus        dmem_if.slave request/response channels
//     dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
//
//   Build option:
//     DMEM_MISALIGN_TRAP_EN  when defined, misaligned H/HU/W accesses return
//                            rsp_err=1 and rsp_rdata=0, and misaligned stores
//                            write nothing. When undefined, H/HU ignore
//                            addr[0] and W ignores addr[1:0].
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
    dmem_if.slave      bus,
    output logic [1:0] dbg_state
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q;
    logic [AW+1:0] addr_q;   // only the bits that select a word and a lane
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [2:0]    mode_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          fire;     // BUSY edge where the access is performed
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic          illegal;
    logic          misalign;
    logic          rejected;
    logic [3:0]    be;
    logic [31:0]   wdata_rep;
    logic [31:0]   load_data;

    assign accept = (state_q == IDLE) && bus.req_valid;
    assign fire   = (state_q == BUSY) && (cnt_q == 4'd0);

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Access decode on the latched request
    always_comb begin
        idx      = addr_q[AW+1:2];
        word     = mem[idx];
        byte_sel = 8'(word >> {addr_q[1:0], 3'b000});
        half_sel = 16'(word >> {addr_q[1], 4'b0000});

        illegal   = 1'b0;
        be        = 4'b0000;
        wdata_rep = wdata_q;
        load_data = 32'd0;
        case (mode_q)
            3'b000: begin
                be        = 4'b0001 << addr_q[1:0];
                wdata_rep = {4{wdata_q[7:0]}};
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            3'b100: load_data = {24'd0, byte_sel};
            3'b001: begin
                be        = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata_q[15:0]}};
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            3'b101: load_data = {16'd0, half_sel};
            3'b010: begin
                be        = 4'b1111;
                load_data = word;
            end
            default: illegal = 1'b1;
        endcase

`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (((mode_q == 3'b001) || (mode_q == 3'b101)) && addr_q[0]) ||
                   ((mode_q == 3'b010) && (addr_q[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        rejected = illegal || misalign;
    end

    // Control and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            mode_q  <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= bus.req_addr[AW+1:0];
                wdata_q <= bus.req_wdata;
                we_q    <= bus.req_we;
                mode_q  <= bus.req_mode;
                cnt_q   <= 4'(LATENCY - 1);
            end else if ((state_q == BUSY) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (fire) begin
                rdata_q <= (we_q || rejected) ? 32'd0 : load_data;
                err_q   <= rejected;
            end
        end
    end

    // Storage is not reset. A reset forces state_q to IDLE, so fire is low
    // and a dropped store never commits.
    always_ff @(posedge clk) begin
        if (fire && we_q && !rejected) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    dmem_if bus();

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard: {err, rdata} expected per issued request
    logic [32:0] exp_q[$];

    // driver: present a request and return after its accept edge (+#1)
    task automatic drive_req(input logic we, input logic [2:0] mode,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic ok);
        @(negedge clk);
        bus.req_we    = we;
        bus.req_mode  = mode;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h: req_ready never high", addr);
        end
        bus.req_valid = 1'b0;
    endtask

    // monitor: wait for the response, check latency and payload against the
    // scoreboard, optionally stall rsp_ready for 'hold' cycles, then handshake
    task automatic collect(input string name, input int hold);
        int n;
        logic [32:0] e;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = exp_q.pop_front();
        total++;
        if (n !== LATENCY) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, n, LATENCY);
        end
        if (!bus.rsp_valid) return;
        total++;
        if (bus.rsp_rdata !== e[31:0]) begin
            bad++;
            $display("FAIL %s_rdata: got %h, expected %h", name, bus.rsp_rdata, e[31:0]);
        end
        total++;
        if (bus.rsp_err !== e[32]) begin
            bad++;
            $display("FAIL %s_err: got %b, expected %b", name, bus.rsp_err, e[32]);
        end
        for (int i = 0; i < hold; i++) begin
            // a stray request pulse during the stall must not be taken
            if (i == 0) begin
                bus.req_addr  = 32'h0000_0020;
                bus.req_we    = 1'b0;
                bus.req_mode  = 3'b010;
                bus.req_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            total++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e[31:0] ||
                bus.rsp_err !== e[32] || bus.req_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s_hold%0d: valid=%b rdata=%h err=%b req_ready=%b, expected 1 %h %b 0",
                         name, i, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                         bus.req_ready, e[31:0], e[32]);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL %s_release: rsp_valid=%b req_ready=%b state=%0d, expected 0 1 0",
                     name, bus.rsp_valid, bus.req_ready, dbg_state);
        end
    endtask

    task automatic txn(input string name, input logic we, input logic [2:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input logic exp_err,
                       input int hold);
        logic ok;
        exp_q.push_back({exp_err, exp_data});
        drive_req(we, mode, addr, wdata, ok);
        if (ok) collect(name, hold);
        else void'(exp_q.pop_back());
    endtask

    task automatic check_reset_outputs(input string name);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 ||
            bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0 || dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL %s: req_ready=%b rsp_valid=%b rdata=%h err=%b state=%0d, expected 1 0 0 0 0",
                     name, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, dbg_state);
        end
    endtask

    task automatic test_reset;
        #1;
        check_reset_outputs("reset_held");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_released");
    endtask

    task automatic test_word;
        txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    endtask

    task automatic test_subword_load;
        txn("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 0);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 0);
        txn("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 0);
        txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 0);
        txn("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, 0);
        txn("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);
    endtask

    task automatic test_partial_store;
        txn("sb_11",   1'b1, 3'b000, 32'h11, 32'h1234_5655, 32'h0, 1'b0, 0);
        txn("lw_sb",   1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 0);
        txn("lbu_11",  1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_0055, 1'b0, 0);
        txn("sh_12",   1'b1, 3'b001, 32'h12, 32'h0000_A5A5, 32'h0, 1'b0, 0);
        txn("lw_sh",   1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
    endtask

    task automatic test_stall;
        txn("lw_stall", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 3);
    endtask

    task automatic test_reset_midop;
        logic ok;
        drive_req(1'b1, 3'b010, 32'h10, 32'h1111_1111, ok);
        if (ok) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            #1;
            check_reset_outputs("reset_midop");
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
        end
        txn("lw_after_rst", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
    endtask

    task automatic test_misalign;
`ifdef DMEM_MISALIGN_TRAP_EN
        txn("lw_12_mis", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
        txn("lh_11_mis", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 0);
        txn("sw_12_mis", 1'b1, 3'b010, 32'h12, 32'hFFFF_FFFF, 32'h0, 1'b1, 0);
        txn("lw_chk_mis", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
`else
        txn("lw_12_al", 1'b0, 3'b010, 32'h12, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
        txn("lh_11_al", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0000_55EF, 1'b0, 0);
`endif
    endtask

    task automatic test_illegal;
        txn("ld_m011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        txn("st_m110", 1'b1, 3'b110, 32'h10, 32'h0000_0000, 32'h0, 1'b1, 0);
        txn("ld_m111", 1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, 0);
        txn("lw_chk_ill", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
    endtask

    task automatic test_wrap;
        logic [31:0] a;
        // aliases of word 4 above the array size must hit the same word
        a = 32'h10 + 32'(4 * DEPTH) * 32'($urandom_range(1, 1000));
        txn("lw_wrap", 1'b0, 3'b010, a, 32'h0, 32'hA5A5_55EF, 1'b0, 0);
        txn("sw_wrap", 1'b1, 3'b010, 32'h8000_0000 | 32'(4 * DEPTH) | 32'h14,
            32'h0BAD_F00D, 32'h0, 1'b0, 0);
        txn("lw_14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_we    = 1'b0;
        bus.req_mode  = 3'd0;
        bus.rsp_ready = 1'b0;

        test_reset;
        test_word;
        test_subword_load;
        test_partial_store;
        test_stall;
        test_reset_midop;
        test_misalign;
        test_illegal;
        test_wrap;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
